// File: rtl/spi_send.sv
// SPI-slave transmitter: AXI-Stream bytes -> FIFO -> LSB-first MISO.
// Define SPI_SEND_UNDERRUN_CNT_EN to add the underrun_cnt output.
module spi_send #(
  parameter int          DEPTH     = 4,
  parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
  input  logic       axi_aclk,
  input  logic       axi_areset,
  input  logic [7:0] axis_tdata,
  input  logic       axis_tvalid,
  output logic       axis_tready,
  input  logic       axis_tlast,
  input  logic       spi_clk,
  input  logic       spi_cs,
  output logic       spi_miso,
  output logic       spi_miso_oe
`ifdef SPI_SEND_UNDERRUN_CNT_EN
  ,
  output logic [7:0] underrun_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  logic [2:0] clk_r;
  logic [2:0] cs_r;
  logic       rise;
  logic       fall;
  logic       cs_on;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      clk_r <= '0;
      cs_r  <= '0;
    end else begin
      clk_r <= {clk_r[1:0], spi_clk};
      cs_r  <= {cs_r[1:0], spi_cs};
    end
  end

  assign rise  = clk_r[1] & ~clk_r[2];
  assign fall  = ~clk_r[1] & clk_r[2];
  assign cs_on = cs_r[1];

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        ready_en;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign axis_tready = ready_en & ~full;
  assign push  = axis_tvalid & axis_tready;

  always_ff @(posedge axi_aclk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= axis_tdata;
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  state_t     state;
  state_t     state_d;
  logic [7:0] shreg;
  logic [7:0] shreg_d;
  logic [2:0] bit_ct;
  logic [2:0] bit_ct_d;
  logic       byte_done;
  logic       done_d;
  logic       miso_d;
  logic       underrun;

  always_comb begin
    state_d  = state;
    shreg_d  = shreg;
    bit_ct_d = bit_ct;
    done_d   = byte_done;
    pop      = 1'b0;
    underrun = 1'b0;
    if (!cs_on) begin
      state_d  = IDLE;
      bit_ct_d = '0;
      done_d   = 1'b0;
    end else begin
      unique case (state)
        IDLE: state_d = LOAD;
        LOAD: begin
          shreg_d  = empty ? IDLE_BYTE
                           : mem[rd_ptr[AW-1:0]];
          pop      = ~empty;
          underrun = empty;
          bit_ct_d = '0;
          state_d  = SHIFT;
        end
        SHIFT: begin
          if (rise) begin
            bit_ct_d = bit_ct + 3'd1;
            if (bit_ct == 3'd7) done_d = 1'b1;
          end
          if (fall) begin
            if (byte_done) begin
              done_d  = 1'b0;
              state_d = LOAD;
            end else begin
              shreg_d = shreg >> 1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    miso_d = (state_d == IDLE) ? 1'b0 : shreg_d[0];
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_ct      <= '0;
      byte_done   <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      state       <= state_d;
      shreg       <= shreg_d;
      bit_ct      <= bit_ct_d;
      byte_done   <= done_d;
      spi_miso    <= miso_d;
      spi_miso_oe <= cs_on;
    end
  end

`ifdef SPI_SEND_UNDERRUN_CNT_EN
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      underrun_cnt <= '0;
    end else if (underrun && underrun_cnt != 8'hFF) begin
      underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
`endif

  // tlast carries no meaning here; the third cs flop only exists for symmetry
  logic unused_ok;
  assign unused_ok = &{1'b0, axis_tlast, cs_r[2]};

endmodule

// File: tb/tb_spi_send.sv
// Randomised bench for spi_send against a byte-queue reference model.
// Honours SPI_SEND_UNDERRUN_CNT_EN when defined.
module tb_spi_send;

  localparam int DEPTH = 4;
  localparam int HALF  = 8;

  logic       axi_aclk = 1'b0;
  logic       axi_areset = 1'b1;
  logic [7:0] axis_tdata = '0;
  logic       axis_tvalid = 1'b0;
  logic       axis_tready;
  logic       axis_tlast = 1'b0;
  logic       spi_clk = 1'b0;
  logic       spi_cs = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
`ifdef SPI_SEND_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt;
`endif

  spi_send #(.DEPTH(DEPTH), .IDLE_BYTE(8'hFF)) dut (
    .axi_aclk    (axi_aclk),
    .axi_areset  (axi_areset),
    .axis_tdata  (axis_tdata),
    .axis_tvalid (axis_tvalid),
    .axis_tready (axis_tready),
    .axis_tlast  (axis_tlast),
    .spi_clk     (spi_clk),
    .spi_cs      (spi_cs),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe)
`ifdef SPI_SEND_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 axi_aclk = ~axi_aclk;

  int checks = 0;
  int passed = 0;

  logic [7:0] q [$];
  int         und_model = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] model_load();
    if (q.size() > 0) return q.pop_front();
    if (und_model < 255) und_model++;
    return 8'hFF;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge axi_aclk);
  endtask

  task automatic push(input logic [7:0] b);
    int t;
    t = 0;
    axis_tvalid = 1'b1;
    axis_tdata  = b;
    axis_tlast  = 1'($urandom_range(0, 1));
    while (!axis_tready && t < 200) begin
      cyc(1);
      t++;
    end
    if (t >= 200) check("push_timeout", 0, 1);
    else q.push_back(b);
    cyc(1);
    axis_tvalid = 1'b0;
  endtask

  task automatic run_frame(input int nbits);
    logic [7:0] rx;
    logic [7:0] exp;
    rx = '0;
    exp = '0;
    spi_cs = 1'b1;
    cyc(6);
    check("oe_on", 32'(spi_miso_oe), 1);
    if (nbits == 0) exp = model_load();
    for (int i = 0; i < nbits; i++) begin
      if (i % 8 == 0) exp = model_load();
      rx[i%8] = spi_miso;
      spi_clk = 1'b1;
      cyc(HALF);
      spi_clk = 1'b0;
      if (i == nbits - 1 && nbits % 8 == 0) spi_cs = 1'b0;
      cyc(HALF);
      if (i % 8 == 7) check("rx_byte", 32'(rx), 32'(exp));
    end
    spi_cs = 1'b0;
    cyc(6);
    check("oe_off", 32'(spi_miso_oe), 0);
    check("miso_idle", 32'(spi_miso), 0);
  endtask

  task automatic check_und();
`ifdef SPI_SEND_UNDERRUN_CNT_EN
    check("underrun_cnt", 32'(underrun_cnt), 32'(und_model));
`endif
  endtask

  initial begin
    #1;
    check("rst_tready", 32'(axis_tready), 0);
    check("rst_miso", 32'(spi_miso), 0);
    check("rst_oe", 32'(spi_miso_oe), 0);
    cyc(3);
    axi_areset = 1'b0;
    cyc(2);
    check("tready_up", 32'(axis_tready), 1);

    push(8'hA5);
    run_frame(8);
    check_und();

    run_frame(8);
    check_und();

    push(8'h01);
    push(8'h80);
    push(8'h3C);
    run_frame(24);
    check_und();

    fork
      begin
        int t;
        axis_tvalid = 1'b1;
        for (int k = 0; k < DEPTH + 1; k++) begin
          axis_tdata = 8'($urandom);
          t = 0;
          while (!axis_tready && t < 2000) begin
            cyc(1);
            t++;
          end
          if (t >= 2000) check("full_timeout", 0, 1);
          else q.push_back(axis_tdata);
          cyc(1);
          if (k == DEPTH - 1)
            check("tready_full", 32'(axis_tready), 0);
        end
        axis_tvalid = 1'b0;
      end
      begin
        cyc(12);
        run_frame(8 * (DEPTH + 1));
      end
    join
    check_und();

    push(8'h55);
    push(8'hC3);
    run_frame(3);
    cyc(20);
    check("oe_gap", 32'(spi_miso_oe), 0);
    run_frame(8);
    check_und();

    for (int r = 0; r < 8; r++) begin
      int np;
      int nb;
      np = $urandom_range(0, DEPTH - q.size());
      for (int k = 0; k < np; k++) push(8'($urandom));
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20)
                                       : 8 * $urandom_range(1, 3);
      run_frame(nb);
      check_und();
    end

    push(8'h96);
    spi_cs = 1'b1;
    cyc(6);
    for (int i = 0; i < 3; i++) begin
      spi_clk = 1'b1;
      cyc(HALF);
      spi_clk = 1'b0;
      cyc(HALF);
    end
    spi_clk = 1'b1;
    cyc(3);
    axi_areset = 1'b1;
    #1;
    check("mid_rst_miso", 32'(spi_miso), 0);
    check("mid_rst_oe", 32'(spi_miso_oe), 0);
    check("mid_rst_tready", 32'(axis_tready), 0);
    spi_clk = 1'b0;
    spi_cs  = 1'b0;
    q.delete();
    und_model = 0;
    cyc(3);
    axi_areset = 1'b0;
    cyc(2);
    check("rel_tready", 32'(axis_tready), 1);
    run_frame(8);
    check_und();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
